// File: rtl/mtx_hop_sequencer.sv
// mtx_hop_sequencer: upstream controller for the tag-chip IQ generator.
// Steps through a sequential or LFSR pseudo-random channel sequence, drives
// the chip's phase handshake, hop increment and soft reset, and checks that
// the chip's hop boundary agrees with a locally counted beat total.
module mtx_hop_sequencer #(
  parameter int                     PHASE_WIDTH  = 24,
  parameter int                     CHAN_BITS    = 3,
  parameter logic [PHASE_WIDTH-1:0] BASE_PH_INC  = 24'h000000,
  parameter logic [PHASE_WIDTH-1:0] CHAN_SPACING = 24'h010000,
  parameter int                     LFSR_WIDTH   = 16,
  parameter int                     HOPS_WIDTH   = 16,
  parameter int                     BEAT_WIDTH   = 20,
  parameter int                     HOP_BEATS    = 294912
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   hop_mode,
  input  logic [LFSR_WIDTH-1:0]  lfsr_seed,
  input  logic [HOPS_WIDTH-1:0]  num_hops,
  input  logic                   hop_ready,
  input  logic                   phase_tready,
  output logic                   phase_tvalid,
  output logic                   phase_tlast,
  output logic [PHASE_WIDTH-1:0] hop_phase_inc,
  output logic                   srst,
  output logic [CHAN_BITS-1:0]   chan_idx,
  output logic [HOPS_WIDTH-1:0]  hop_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   sync_err
);

  localparam logic [BEAT_WIDTH-1:0] HOP_BEATS_C = BEAT_WIDTH'(HOP_BEATS);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT_C = BEAT_WIDTH'(HOP_BEATS - 1);
  localparam logic [BEAT_WIDTH-1:0] BEAT_MAX_C  = {BEAT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SYNC = 3'd2,
    S_RUN  = 3'd3,
    S_ADV  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Fibonacci LFSR step: shift left, feedback taps 16/14/13/11.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
    return {cur[LFSR_WIDTH-2:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Channel increment: base plus channel times spacing, wrapping at PHASE_WIDTH.
  function automatic logic [PHASE_WIDTH-1:0] chan_inc(input logic [CHAN_BITS-1:0] ch);
    logic [PHASE_WIDTH-1:0] ch_ext;
    ch_ext = {{(PHASE_WIDTH-CHAN_BITS){1'b0}}, ch};
    return BASE_PH_INC + (CHAN_SPACING * ch_ext);
  endfunction

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [HOPS_WIDTH-1:0]  num_hops_q, num_hops_d;
  logic [HOPS_WIDTH-1:0]  hop_cnt_q, hop_cnt_d;
  logic [CHAN_BITS-1:0]   chan_q, chan_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [BEAT_WIDTH-1:0]  beat_q, beat_d;
  logic                   sync_err_q, sync_err_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   srst_q, srst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LFSR_WIDTH-1:0]  seed_eff;
  logic [LFSR_WIDTH-1:0]  lfsr_next;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_eff  = (lfsr_seed == {LFSR_WIDTH{1'b0}}) ? LFSR_WIDTH'(1) : lfsr_seed;
  assign lfsr_next = lfsr_step(lfsr_q);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lfsr_d     = lfsr_q;
    num_hops_d = num_hops_q;
    hop_cnt_d  = hop_cnt_q;
    chan_d     = chan_q;
    inc_d      = inc_q;
    beat_d     = beat_q;
    sync_err_d = sync_err_q;

    if (stop && (state_q != S_IDLE)) begin
      // Abort wins over everything, including a pending hop_ready.
      state_d = S_IDLE;
      beat_d  = {BEAT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            mode_d     = hop_mode;
            lfsr_d     = seed_eff;
            num_hops_d = num_hops;
            sync_err_d = 1'b0;
            hop_cnt_d  = {HOPS_WIDTH{1'b0}};
            beat_d     = {BEAT_WIDTH{1'b0}};
            chan_d     = hop_mode ? seed_eff[CHAN_BITS-1:0] : {CHAN_BITS{1'b0}};
            state_d    = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          inc_d   = chan_inc(chan_q);
          state_d = S_SYNC;
        end
        S_SYNC: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (tvalid_q && phase_tready && (beat_q != BEAT_MAX_C)) begin
            beat_d = beat_q + BEAT_WIDTH'(1);
          end else begin
            beat_d = beat_q;
          end
          if (hop_ready) begin
            state_d = S_ADV;
          end else begin
            state_d = S_RUN;
          end
        end
        S_ADV: begin
          if (beat_q != HOP_BEATS_C) begin
            sync_err_d = 1'b1;
          end else begin
            sync_err_d = sync_err_q;
          end
          hop_cnt_d = hop_cnt_q + HOPS_WIDTH'(1);
          beat_d    = {BEAT_WIDTH{1'b0}};
          if ((num_hops_q != {HOPS_WIDTH{1'b0}}) && (hop_cnt_d == num_hops_q)) begin
            state_d = S_DONE;
          end else if (mode_q) begin
            lfsr_d  = lfsr_next;
            chan_d  = lfsr_next[CHAN_BITS-1:0];
            state_d = S_LOAD;
          end else begin
            chan_d  = chan_q + CHAN_BITS'(1);
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered from the state being entered.
    tvalid_d = (state_d == S_RUN);
    tlast_d  = (state_d == S_RUN) && (beat_d == LAST_BEAT_C);
    srst_d   = (state_d != S_RUN) && (state_d != S_ADV);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      lfsr_q     <= LFSR_WIDTH'(1);
      num_hops_q <= {HOPS_WIDTH{1'b0}};
      hop_cnt_q  <= {HOPS_WIDTH{1'b0}};
      chan_q     <= {CHAN_BITS{1'b0}};
      inc_q      <= BASE_PH_INC;
      beat_q     <= {BEAT_WIDTH{1'b0}};
      sync_err_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      srst_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lfsr_q     <= lfsr_d;
      num_hops_q <= num_hops_d;
      hop_cnt_q  <= hop_cnt_d;
      chan_q     <= chan_d;
      inc_q      <= inc_d;
      beat_q     <= beat_d;
      sync_err_q <= sync_err_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      srst_q     <= srst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign phase_tvalid  = tvalid_q;
  assign phase_tlast   = tlast_q;
  assign hop_phase_inc = inc_q;
  assign srst          = srst_q;
  assign chan_idx      = chan_q;
  assign hop_cnt       = hop_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_mtx_hop_sequencer.sv
// Directed bench for mtx_hop_sequencer with a 16-beat hop and a simple chip
// model that raises hop_ready after 16 valid cycles and clears it on srst.
module tb_mtx_hop_sequencer;

  localparam int HB = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        stop;
  logic        hop_mode;
  logic [15:0] lfsr_seed;
  logic [15:0] num_hops;
  logic        hop_ready = 1'b0;
  logic        phase_tready;
  logic        phase_tvalid;
  logic        phase_tlast;
  logic [23:0] hop_phase_inc;
  logic        srst;
  logic [2:0]  chan_idx;
  logic [15:0] hop_cnt;
  logic        busy;
  logic        done;
  logic        sync_err;

  logic        tready_en;
  int          chip_cnt = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mtx_hop_sequencer #(.HOP_BEATS(HB)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .hop_mode(hop_mode), .lfsr_seed(lfsr_seed), .num_hops(num_hops),
    .hop_ready(hop_ready), .phase_tready(phase_tready),
    .phase_tvalid(phase_tvalid), .phase_tlast(phase_tlast),
    .hop_phase_inc(hop_phase_inc), .srst(srst), .chan_idx(chan_idx),
    .hop_cnt(hop_cnt), .busy(busy), .done(done), .sync_err(sync_err)
  );

  // Chip model: stops accepting once its hop is complete.
  assign phase_tready = tready_en & ~hop_ready;

  // Chip model: hop_ready after HB valid cycles, cleared by srst.
  always @(posedge clk) begin
    if (srst) begin
      hop_ready <= 1'b0;
      chip_cnt  <= 0;
    end else if (phase_tvalid && !hop_ready) begin
      if (chip_cnt == HB - 1) hop_ready <= 1'b1;
      chip_cnt <= chip_cnt + 1;
    end
  end

  // Monitor: log each hop start, srst before it, latency, done and tlast beats.
  int          cyc = 0;
  int          hr_cyc = 0;
  int          srst_ok = 0;
  int          done_cnt = 0;
  int          tlast_cnt = 0;
  logic        prev_tvalid = 1'b0;
  logic        prev_srst = 1'b0;
  logic        prev_hr = 1'b0;
  logic [23:0] inc_log[$];
  logic [2:0]  chan_log[$];
  int          lat_log[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (phase_tvalid && !prev_tvalid) begin
      inc_log.push_back(hop_phase_inc);
      chan_log.push_back(chan_idx);
      lat_log.push_back(cyc - hr_cyc);
      if (prev_srst) srst_ok <= srst_ok + 1;
    end
    if (hop_ready && !prev_hr) hr_cyc <= cyc;
    if (done) done_cnt <= done_cnt + 1;
    if (phase_tlast && phase_tvalid && phase_tready) tlast_cnt <= tlast_cnt + 1;
    prev_tvalid <= phase_tvalid;
    prev_srst   <= srst;
    prev_hr     <= hop_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic m, input logic [15:0] seed, input logic [15:0] n);
    @(negedge clk);
    hop_mode  = m;
    lfsr_seed = seed;
    num_hops  = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_tvalid(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (phase_tvalid) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_hopcnt(input string tag, input logic [15:0] n, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (hop_cnt == n) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int b, d0, t0, s0, hc;
    int exp_ch[4];

    resetn = 1'b0; start = 1'b0; stop = 1'b0; hop_mode = 1'b0;
    lfsr_seed = 16'h0000; num_hops = 16'd0; tready_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, phase_tvalid}, 32'd0);
    chk("rst_tlast",  {31'd0, phase_tlast}, 32'd0);
    chk("rst_srst",   {31'd0, srst}, 32'd1);
    chk("rst_inc",    {8'd0, hop_phase_inc}, 32'h0);
    chk("rst_chan",   {29'd0, chan_idx}, 32'd0);
    chk("rst_hopcnt", {16'd0, hop_cnt}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_syncerr",{31'd0, sync_err}, 32'd0);
    resetn = 1'b1;

    // Sequential, 3 hops.
    b = inc_log.size(); d0 = done_cnt; t0 = tlast_cnt; s0 = srst_ok;
    pulse_start(1'b0, 16'h0000, 16'd3);
    chk("seq3_busy", {31'd0, busy}, 32'd1);
    wait_done("seq3_done_seen", 400);
    chk("seq3_done_srst", {31'd0, srst}, 32'd1);
    step();
    chk("seq3_done_pulse", {31'd0, done}, 32'd0);
    chk("seq3_idle", {31'd0, busy}, 32'd0);
    chk("seq3_hopcnt", {16'd0, hop_cnt}, 32'd3);
    chk("seq3_syncerr", {31'd0, sync_err}, 32'd0);
    repeat (3) step();
    chk("seq3_ndone", done_cnt - d0, 32'd1);
    chk("seq3_nhops", inc_log.size() - b, 32'd3);
    chk("seq3_inc0", {8'd0, inc_log[b]}, 32'h000000);
    chk("seq3_inc1", {8'd0, inc_log[b+1]}, 32'h010000);
    chk("seq3_inc2", {8'd0, inc_log[b+2]}, 32'h020000);
    chk("seq3_srst_before", srst_ok - s0, 32'd3);
    chk("seq3_tlast", tlast_cnt - t0, 32'd3);
    chk("seq3_lat1", lat_log[b+1], 32'd4);
    chk("seq3_lat2", lat_log[b+2], 32'd4);

    // Sequential wrap, 10 hops.
    b = inc_log.size();
    pulse_start(1'b0, 16'h0000, 16'd10);
    wait_done("wrap_done_seen", 1000);
    step();
    chk("wrap_hopcnt", {16'd0, hop_cnt}, 32'd10);
    chk("wrap_nhops", inc_log.size() - b, 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap_chan%0d", i), {29'd0, chan_log[b+i]}, i % 8);
    end
    chk("wrap_inc9", {8'd0, inc_log[b+9]}, 32'h010000);

    // Random, seed 1 and seed 0.
    exp_ch = '{1, 2, 4, 0};
    b = inc_log.size();
    pulse_start(1'b1, 16'h0001, 16'd4);
    wait_done("rnd1_done_seen", 500);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd1_chan%0d", i), {29'd0, chan_log[b+i]}, exp_ch[i]);
    end
    chk("rnd1_inc2", {8'd0, inc_log[b+2]}, 32'h040000);
    b = inc_log.size();
    pulse_start(1'b1, 16'h0000, 16'd4);
    wait_done("rnd0_done_seen", 500);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd0_chan%0d", i), {29'd0, chan_log[b+i]}, exp_ch[i]);
    end

    // Stall: 3 refused beats while the chip still ends its hop on time.
    pulse_start(1'b0, 16'h0000, 16'd2);
    wait_tvalid("stall_run", 20);
    repeat (5) step();
    tready_en = 1'b0;
    repeat (3) step();
    tready_en = 1'b1;
    wait_hopcnt("stall_hop1", 16'd1, 100);
    chk("stall_err_set", {31'd0, sync_err}, 32'd1);
    chk("stall_continues", {31'd0, busy}, 32'd1);
    wait_done("stall_done_seen", 200);
    step();
    chk("stall_err_sticky", {31'd0, sync_err}, 32'd1);
    chk("stall_hopcnt", {16'd0, hop_cnt}, 32'd2);

    // Stop in RUN; next start clears sync_err.
    d0 = done_cnt;
    pulse_start(1'b0, 16'h0000, 16'd5);
    chk("stop_err_cleared", {31'd0, sync_err}, 32'd0);
    wait_tvalid("stop_run", 20);
    repeat (4) step();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_srst", {31'd0, srst}, 32'd1);
    chk("stop_tvalid", {31'd0, phase_tvalid}, 32'd0);
    repeat (4) step();
    chk("stop_no_done", done_cnt - d0, 32'd0);

    // start together with stop in IDLE is ignored.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    chk("startstop_idle", {31'd0, busy}, 32'd0);

    // Endless mode: 20 hops, start pulses during RUN ignored.
    b = inc_log.size(); d0 = done_cnt;
    pulse_start(1'b0, 16'h0000, 16'd0);
    wait_tvalid("endless_run", 20);
    hc = hop_cnt;
    pulse_start(1'b1, 16'h0005, 16'd2);
    #1;
    chk("endless_start_ign_cnt", {16'd0, hop_cnt}, hc);
    chk("endless_start_ign_run", {31'd0, phase_tvalid}, 32'd1);
    wait_hopcnt("endless_20", 16'd20, 1000);
    chk("endless_chan20", {29'd0, chan_idx}, 32'd4);
    chk("endless_no_done", done_cnt - d0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("endless_chan%0d", i), {29'd0, chan_log[b+i]}, i % 8);
    end

    // Reset mid-hop, then restart at hop 0.
    wait_tvalid("rst_mid_run", 20);
    repeat (3) step();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("rstm_tvalid", {31'd0, phase_tvalid}, 32'd0);
    chk("rstm_srst",   {31'd0, srst}, 32'd1);
    chk("rstm_inc",    {8'd0, hop_phase_inc}, 32'h0);
    chk("rstm_chan",   {29'd0, chan_idx}, 32'd0);
    chk("rstm_hopcnt", {16'd0, hop_cnt}, 32'd0);
    chk("rstm_busy",   {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    b = inc_log.size();
    pulse_start(1'b0, 16'h0000, 16'd1);
    wait_done("rstm_done_seen", 200);
    step();
    chk("rstm_restart_chan", {29'd0, chan_log[b]}, 32'd0);
    chk("rstm_restart_cnt", {16'd0, hop_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
